// File: rtl/ysyx_24080006_scoreboard_if.sv
// Issue / operand-lookup / writeback / commit bundle of the scoreboard.
// The slave modport is the scoreboard side; the master modport is the core side.
interface ysyx_24080006_scoreboard_if #(
  parameter int IDX_W       = 2,
  parameter int NR_WB_PORTS = 2,
  parameter int REG_W       = 5
);
  logic                         issue_valid_i;
  logic                         issue_ready_o;
  logic [3:0]                   issue_fu_i;
  logic [REG_W-1:0]             issue_rd_i;
  logic                         issue_we_i;
  logic [31:0]                  issue_pc_i;
  logic [IDX_W-1:0]             issue_trans_id_o;
  logic [REG_W-1:0]             rs1_addr_i;
  logic [REG_W-1:0]             rs2_addr_i;
  logic                         rs1_busy_o;
  logic                         rs2_busy_o;
  logic                         rs1_fwd_o;
  logic                         rs2_fwd_o;
  logic [31:0]                  rs1_data_o;
  logic [31:0]                  rs2_data_o;
  logic [NR_WB_PORTS-1:0]       wb_valid_i;
  logic [NR_WB_PORTS*IDX_W-1:0] wb_trans_id_i;
  logic [NR_WB_PORTS*32-1:0]    wb_data_i;
  logic                         commit_valid_o;
  logic                         commit_ready_i;
  logic                         commit_we_o;
  logic [REG_W-1:0]             commit_rd_o;
  logic [31:0]                  commit_data_o;
  logic [31:0]                  commit_pc_o;
  logic [3:0]                   commit_fu_o;

  modport slave (
    input  issue_valid_i, issue_fu_i, issue_rd_i, issue_we_i, issue_pc_i,
    output issue_ready_o, issue_trans_id_o,
    input  rs1_addr_i, rs2_addr_i,
    output rs1_busy_o, rs2_busy_o, rs1_fwd_o, rs2_fwd_o, rs1_data_o, rs2_data_o,
    input  wb_valid_i, wb_trans_id_i, wb_data_i,
    output commit_valid_o, commit_we_o, commit_rd_o, commit_data_o, commit_pc_o, commit_fu_o,
    input  commit_ready_i
  );

  modport master (
    output issue_valid_i, issue_fu_i, issue_rd_i, issue_we_i, issue_pc_i,
    input  issue_ready_o, issue_trans_id_o,
    output rs1_addr_i, rs2_addr_i,
    input  rs1_busy_o, rs2_busy_o, rs1_fwd_o, rs2_fwd_o, rs1_data_o, rs2_data_o,
    output wb_valid_i, wb_trans_id_i, wb_data_i,
    input  commit_valid_o, commit_we_o, commit_rd_o, commit_data_o, commit_pc_o, commit_fu_o,
    output commit_ready_i
  );
endinterface

// File: rtl/ysyx_24080006_scoreboard.sv
// In-order issue / out-of-order writeback / in-order commit circular buffer.
// Issue, lookup and commit are combinational from registered state; writeback lands next edge.
module ysyx_24080006_scoreboard #(
  parameter int NR_ENTRIES  = 4,
  parameter int IDX_W       = 2,
  parameter int NR_WB_PORTS = 2,
  parameter int REG_W       = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic flush_i,
  ysyx_24080006_scoreboard_if.slave sb
);

  typedef struct packed {
    logic             valid;
    logic             done;
    logic [3:0]       fu;
    logic [REG_W-1:0] rd;
    logic             we;
    logic [31:0]      pc;
    logic [31:0]      data;
  } entry_t;

  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(NR_ENTRIES);

  entry_t [NR_ENTRIES-1:0] mem_q, mem_d;
  logic [IDX_W-1:0]        head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]          count_q, count_d;

  logic issue_fire, commit_fire;

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign sb.issue_ready_o    = (count_q != FULL) && !flush_i;
  assign sb.issue_trans_id_o = tail_q;
  assign issue_fire          = sb.issue_valid_i && sb.issue_ready_o;

  assign sb.commit_valid_o = mem_q[head_q].valid && mem_q[head_q].done && !flush_i;
  assign sb.commit_we_o    = mem_q[head_q].we;
  assign sb.commit_rd_o    = mem_q[head_q].rd;
  assign sb.commit_data_o  = mem_q[head_q].data;
  assign sb.commit_pc_o    = mem_q[head_q].pc;
  assign sb.commit_fu_o    = mem_q[head_q].fu;
  assign commit_fire       = sb.commit_valid_o && sb.commit_ready_i;

  always_comb begin
    logic [IDX_W-1:0] wb_id;
    wb_id   = '0;
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        mem_d[i].valid = 1'b0;
        mem_d[i].done  = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Walk ports high to low so the lower index overwrites on an ID clash.
      for (int p = NR_WB_PORTS - 1; p >= 0; p--) begin
        wb_id = sb.wb_trans_id_i[p*IDX_W +: IDX_W];
        if (sb.wb_valid_i[p] && mem_q[wb_id].valid) begin
          mem_d[wb_id].done = 1'b1;
          mem_d[wb_id].data = sb.wb_data_i[p*32 +: 32];
        end
      end
      if (commit_fire) begin
        mem_d[head_q].valid = 1'b0;
        mem_d[head_q].done  = 1'b0;
        head_d              = head_q + 1'b1;
      end
      if (issue_fire) begin
        mem_d[tail_q].valid = 1'b1;
        mem_d[tail_q].done  = 1'b0;
        mem_d[tail_q].fu    = sb.issue_fu_i;
        mem_d[tail_q].rd    = sb.issue_rd_i;
        mem_d[tail_q].we    = sb.issue_we_i;
        mem_d[tail_q].pc    = sb.issue_pc_i;
        mem_d[tail_q].data  = '0;
        tail_d              = tail_q + 1'b1;
      end
      count_d = count_q + (IDX_W+1)'(issue_fire) - (IDX_W+1)'(commit_fire);
    end
  end

  // Operand lookup: scan oldest to youngest so the youngest matching writer wins.
  always_comb begin
    logic [IDX_W-1:0] idx;
    logic             m1, d1, m2, d2;
    logic [31:0]      v1, v2;
    idx = '0;
    m1  = 1'b0;
    d1  = 1'b0;
    v1  = '0;
    m2  = 1'b0;
    d2  = 1'b0;
    v2  = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      idx = head_q + IDX_W'(i);
      if (mem_q[idx].valid && mem_q[idx].we) begin
        if (mem_q[idx].rd == sb.rs1_addr_i) begin
          m1 = 1'b1;
          d1 = mem_q[idx].done;
          v1 = mem_q[idx].data;
        end
        if (mem_q[idx].rd == sb.rs2_addr_i) begin
          m2 = 1'b1;
          d2 = mem_q[idx].done;
          v2 = mem_q[idx].data;
        end
      end
    end
    if (sb.rs1_addr_i == '0) m1 = 1'b0;
    if (sb.rs2_addr_i == '0) m2 = 1'b0;
    sb.rs1_busy_o = m1 && !d1;
    sb.rs1_fwd_o  = m1 && d1;
    sb.rs1_data_o = (m1 && d1) ? v1 : '0;
    sb.rs2_busy_o = m2 && !d2;
    sb.rs2_fwd_o  = m2 && d2;
    sb.rs2_data_o = (m2 && d2) ? v2 : '0;
  end

endmodule

// File: tb/tb_ysyx_24080006_scoreboard.sv
// Self-checking bench: directed table, hand-written corner sequences and a random run
// compared every cycle against a queue-based reference model.
module tb_ysyx_24080006_scoreboard;

  logic clock = 1'b0;
  logic reset;
  logic flush;
  always #5 clock = ~clock;

  ysyx_24080006_scoreboard_if #(.IDX_W(2), .NR_WB_PORTS(2), .REG_W(5)) sif ();

  ysyx_24080006_scoreboard #(.NR_ENTRIES(4), .IDX_W(2), .NR_WB_PORTS(2), .REG_W(5)) dut (
    .clock   (clock),
    .reset   (reset),
    .flush_i (flush),
    .sb      (sif)
  );

  typedef struct {
    logic [1:0]  id;
    logic [3:0]  fu;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] pc;
    logic        done;
    logic [31:0] data;
  } ment_t;

  ment_t mq[$];
  int    m_tail    = 0;
  int    n_tests   = 0;
  int    n_fail    = 0;
  int    n_commits = 0;
  bit    check_en  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_lookup(input logic [4:0] rs, output logic busy, output logic fwd,
                              output logic [31:0] data);
    busy = 0;
    fwd  = 0;
    data = 0;
    if (rs != 0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].we && mq[i].rd == rs) begin
          busy = !mq[i].done;
          fwd  = mq[i].done;
          data = mq[i].data;
          break;
        end
      end
    end
  endtask

  task automatic model_check();
    logic        b, f;
    logic [31:0] d;
    logic        e_cv;
    chk("issue_ready", 32'(sif.issue_ready_o), 32'((mq.size() < 4) && !flush));
    chk("issue_trans_id", 32'(sif.issue_trans_id_o), 32'(m_tail));
    e_cv = (mq.size() > 0) && mq[0].done && !flush;
    chk("commit_valid", 32'(sif.commit_valid_o), 32'(e_cv));
    if (e_cv) begin
      chk("commit_rd", 32'(sif.commit_rd_o), 32'(mq[0].rd));
      chk("commit_data", sif.commit_data_o, mq[0].data);
      chk("commit_pc", sif.commit_pc_o, mq[0].pc);
      chk("commit_fu", 32'(sif.commit_fu_o), 32'(mq[0].fu));
      chk("commit_we", 32'(sif.commit_we_o), 32'(mq[0].we));
    end
    model_lookup(sif.rs1_addr_i, b, f, d);
    chk("rs1_busy", 32'(sif.rs1_busy_o), 32'(b));
    chk("rs1_fwd", 32'(sif.rs1_fwd_o), 32'(f));
    if (f) chk("rs1_data", sif.rs1_data_o, d);
    model_lookup(sif.rs2_addr_i, b, f, d);
    chk("rs2_busy", 32'(sif.rs2_busy_o), 32'(b));
    chk("rs2_fwd", 32'(sif.rs2_fwd_o), 32'(f));
    if (f) chk("rs2_data", sif.rs2_data_o, d);
  endtask

  task automatic model_update();
    bit         rdy, cv;
    logic [1:0] id;
    ment_t      e;
    if (reset || flush) begin
      mq.delete();
      m_tail = 0;
      return;
    end
    rdy = mq.size() < 4;
    cv  = (mq.size() > 0) && mq[0].done;
    for (int p = 1; p >= 0; p--) begin
      if (sif.wb_valid_i[p]) begin
        id = sif.wb_trans_id_i[p*2 +: 2];
        foreach (mq[i]) begin
          if (mq[i].id == id) begin
            mq[i].done = 1;
            mq[i].data = sif.wb_data_i[p*32 +: 32];
          end
        end
      end
    end
    if (cv && sif.commit_ready_i) begin
      void'(mq.pop_front());
      n_commits++;
    end
    if (rdy && sif.issue_valid_i) begin
      e.id   = 2'(m_tail);
      e.fu   = sif.issue_fu_i;
      e.rd   = sif.issue_rd_i;
      e.we   = sif.issue_we_i;
      e.pc   = sif.issue_pc_i;
      e.done = 0;
      e.data = 0;
      mq.push_back(e);
      m_tail = (m_tail + 1) % 4;
    end
  endtask

  task automatic to_neg();
    @(negedge clock);
    if (check_en) model_check();
  endtask

  task automatic to_pos();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle();
    sif.issue_valid_i  = 0;
    sif.issue_fu_i     = 0;
    sif.issue_rd_i     = 0;
    sif.issue_we_i     = 0;
    sif.issue_pc_i     = 0;
    sif.wb_valid_i     = 0;
    sif.wb_trans_id_i  = 0;
    sif.wb_data_i      = 0;
    sif.commit_ready_i = 0;
    flush              = 0;
  endtask

  task automatic set_issue(input logic [4:0] rd);
    sif.issue_valid_i = 1;
    sif.issue_fu_i    = 4'h1;
    sif.issue_rd_i    = rd;
    sif.issue_we_i    = 1;
    sif.issue_pc_i    = 32'h8000_0000 + 32'(rd) * 4;
  endtask

  task automatic set_wb(input int p, input logic [1:0] id, input logic [31:0] d);
    sif.wb_valid_i[p]            = 1;
    sif.wb_trans_id_i[p*2 +: 2]  = id;
    sif.wb_data_i[p*32 +: 32]    = d;
  endtask

  task automatic do_flush();
    idle();
    flush = 1;
    to_neg();
    to_pos();
    idle();
  endtask

  typedef struct {
    logic        iv;
    logic [4:0]  rd;
    logic        wbv;
    logic [1:0]  wid;
    logic [31:0] wd;
    logic        cr;
    logic        e_rdy;
    logic [1:0]  e_tid;
    logic        e_cv;
    logic [4:0]  e_crd;
    logic [31:0] e_cdat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int base;
    vecs[0]  = '{1, 1, 0, 0, 0,        1, 1, 0, 0, 0, 0};
    vecs[1]  = '{1, 2, 0, 0, 0,        1, 1, 1, 0, 0, 0};
    vecs[2]  = '{1, 3, 0, 0, 0,        1, 1, 2, 0, 0, 0};
    vecs[3]  = '{1, 4, 0, 0, 0,        1, 1, 3, 0, 0, 0};
    vecs[4]  = '{1, 6, 1, 2, 32'h22,   1, 0, 0, 0, 0, 0};
    vecs[5]  = '{1, 6, 1, 0, 32'h11,   1, 0, 0, 0, 0, 0};
    vecs[6]  = '{1, 6, 0, 0, 0,        1, 0, 0, 1, 1, 32'h11};
    vecs[7]  = '{1, 6, 0, 0, 0,        1, 1, 0, 0, 0, 0};
    vecs[8]  = '{0, 0, 1, 1, 32'h33,   1, 0, 1, 0, 0, 0};
    vecs[9]  = '{0, 0, 0, 0, 0,        1, 0, 1, 1, 2, 32'h33};
    vecs[10] = '{0, 0, 0, 0, 0,        1, 1, 1, 1, 3, 32'h22};
    vecs[11] = '{0, 0, 0, 0, 0,        1, 1, 1, 0, 0, 0};

    idle();
    sif.rs1_addr_i = 5'd1;
    sif.rs2_addr_i = 5'd3;
    reset = 1;
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
    mq.delete();
    m_tail   = 0;
    check_en = 1;

    // Reset state
    @(negedge clock);
    chk("rst_issue_ready", 32'(sif.issue_ready_o), 1);
    chk("rst_trans_id", 32'(sif.issue_trans_id_o), 0);
    chk("rst_commit_valid", 32'(sif.commit_valid_o), 0);
    chk("rst_rs1_busy_fwd", 32'({sif.rs1_busy_o, sif.rs1_fwd_o}), 0);
    chk("rst_rs2_busy_fwd", 32'({sif.rs2_busy_o, sif.rs2_fwd_o}), 0);
    chk("rst_rs_data", sif.rs1_data_o | sif.rs2_data_o, 0);
    to_pos();

    // Fill, out-of-order writeback, in-order commit
    for (int i = 0; i < 12; i++) begin
      idle();
      if (vecs[i].iv) set_issue(vecs[i].rd);
      if (vecs[i].wbv) set_wb(0, vecs[i].wid, vecs[i].wd);
      sif.commit_ready_i = vecs[i].cr;
      to_neg();
      chk($sformatf("vec%0d_ready", i), 32'(sif.issue_ready_o), 32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_tid", i), 32'(sif.issue_trans_id_o), 32'(vecs[i].e_tid));
      chk($sformatf("vec%0d_cvalid", i), 32'(sif.commit_valid_o), 32'(vecs[i].e_cv));
      if (vecs[i].e_cv) begin
        chk($sformatf("vec%0d_crd", i), 32'(sif.commit_rd_o), 32'(vecs[i].e_crd));
        chk($sformatf("vec%0d_cdata", i), sif.commit_data_o, vecs[i].e_cdat);
      end
      to_pos();
    end

    // Youngest writer decides busy/forward
    do_flush();
    set_issue(5); to_neg(); to_pos();
    set_issue(5); to_neg(); chk("dup_rd_tid1", 32'(sif.issue_trans_id_o), 1); to_pos();
    idle(); set_wb(0, 2'd0, 32'hA); to_neg(); to_pos();
    idle(); sif.rs1_addr_i = 5; sif.rs2_addr_i = 0;
    to_neg();
    chk("youngest_busy", 32'(sif.rs1_busy_o), 1);
    chk("youngest_nofwd", 32'(sif.rs1_fwd_o), 0);
    chk("x0_never_busy", 32'({sif.rs2_busy_o, sif.rs2_fwd_o}), 0);
    to_pos();
    set_wb(0, 2'd1, 32'hB); to_neg(); to_pos();
    idle(); to_neg();
    chk("youngest_fwd", 32'(sif.rs1_fwd_o), 1);
    chk("youngest_data", sif.rs1_data_o, 32'hB);
    chk("youngest_notbusy", 32'(sif.rs1_busy_o), 0);
    to_pos();

    // Dual-port writeback, same-ID clash
    do_flush();
    for (int r = 7; r <= 10; r++) begin
      set_issue(5'(r)); to_neg(); to_pos();
    end
    idle();
    set_wb(0, 2'd1, 32'h81);
    set_wb(1, 2'd3, 32'h83);
    to_neg(); to_pos();
    idle(); sif.rs1_addr_i = 8; sif.rs2_addr_i = 10;
    to_neg();
    chk("dual_wb_fwd", 32'({sif.rs1_fwd_o, sif.rs2_fwd_o}), 32'h3);
    chk("dual_wb_p0_data", sif.rs1_data_o, 32'h81);
    chk("dual_wb_p1_data", sif.rs2_data_o, 32'h83);
    to_pos();
    set_wb(0, 2'd0, 32'hAA);
    set_wb(1, 2'd0, 32'hBB);
    to_neg(); to_pos();
    idle(); sif.rs1_addr_i = 7;
    to_neg();
    chk("clash_port0_wins", sif.rs1_data_o, 32'hAA);
    to_pos();

    // Full buffer: commit this cycle, issue accepted only on the next
    set_wb(0, 2'd2, 32'h82); to_neg(); to_pos();
    idle(); set_issue(11); sif.commit_ready_i = 1;
    to_neg();
    chk("full_no_bypass_ready", 32'(sif.issue_ready_o), 0);
    chk("full_commit_valid", 32'(sif.commit_valid_o), 1);
    chk("full_commit_rd", 32'(sif.commit_rd_o), 7);
    to_pos();
    sif.commit_ready_i = 0;
    to_neg();
    chk("after_commit_ready", 32'(sif.issue_ready_o), 1);
    chk("after_commit_tid", 32'(sif.issue_trans_id_o), 0);
    to_pos();

    // Streaming issue/commit pairs with pointer wrap
    base = n_commits;
    for (int c = 0; c < 200 && (n_commits - base) < 20; c++) begin
      idle();
      set_issue(5'($urandom_range(1, 7)));
      sif.issue_pc_i     = $urandom;
      sif.commit_ready_i = 1;
      set_wb(0, 2'(m_tail + 3), $urandom);
      if (mq.size() > 0) set_wb(1, mq[0].id, $urandom);
      to_neg(); to_pos();
    end
    chk("twenty_commits", 32'((n_commits - base) >= 20), 1);

    // Flush beats concurrent issue and commit
    do_flush();
    for (int r = 1; r <= 3; r++) begin
      set_issue(5'(r)); to_neg(); to_pos();
    end
    idle(); set_wb(0, 2'd0, 32'h55); to_neg(); to_pos();
    idle(); set_issue(9); sif.commit_ready_i = 1; flush = 1;
    to_neg();
    chk("flush_commit_blocked", 32'(sif.commit_valid_o), 0);
    chk("flush_issue_blocked", 32'(sif.issue_ready_o), 0);
    to_pos();
    idle(); set_issue(9);
    to_neg();
    chk("post_flush_tid", 32'(sif.issue_trans_id_o), 0);
    chk("post_flush_empty", 32'(sif.commit_valid_o), 0);
    to_pos();
    idle(); to_neg();
    chk("post_flush_alloc", 32'(sif.issue_trans_id_o), 1);
    to_pos();

    // Random traffic including flush and mid-run reset
    for (int c = 0; c < 600; c++) begin
      idle();
      if ($urandom_range(0, 9) < 7) begin
        sif.issue_valid_i = 1;
        sif.issue_fu_i    = 4'($urandom);
        sif.issue_rd_i    = 5'($urandom_range(0, 7));
        sif.issue_we_i    = 1'($urandom_range(0, 3) != 0);
        sif.issue_pc_i    = $urandom;
      end
      for (int p = 0; p < 2; p++)
        if ($urandom_range(0, 9) < 4) set_wb(p, 2'($urandom), $urandom);
      sif.commit_ready_i = 1'($urandom_range(0, 9) < 7);
      sif.rs1_addr_i     = 5'($urandom_range(0, 7));
      sif.rs2_addr_i     = 5'($urandom_range(0, 7));
      flush              = 1'($urandom_range(0, 99) < 3);
      reset              = 1'($urandom_range(0, 99) < 1);
      to_neg();
      to_pos();
      reset = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
